fifo_rd_ctrl: RTL and testbench

//  Read-side controller for the fifo: drives dpram port B as a pure reader and

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_rd_skid.sv | 71 +++++++
 rtl/fifo_rd_ctrl.sv | 70 +++++++
 tb/tb_fifo_rd_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and types shared by the fifo read- and write-side controllers
package fifo_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int PTR_W  = ADDR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 2-entry first-word-fall-through output buffer, head held in entry 0
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA = DATA_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [DATA-1:0] data_in,
    input  logic            pop,
    output logic [DATA-1:0] data_out,
    output logic            valid,
    output logic [1:0]      occ
);

    occ_e            state, state_nxt;
    logic [DATA-1:0] e0, e0_nxt, e1, e1_nxt;
    logic            take;

    assign take     = pop & valid;
    assign valid    = state != OCC_EMPTY;
    assign occ      = state;
    assign data_out = e0;

    // occupancy state and entry registers; reset empties the buffer and zeroes the head
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= OCC_EMPTY;
            e0    <= '0;
            e1    <= '0;
        end else begin
            state <= state_nxt;
            e0    <= e0_nxt;
            e1    <= e1_nxt;
        end
    end

    // shift head out on pop, append incoming word at the tail
    always_comb begin
        state_nxt = state;
        e0_nxt    = e0;
        e1_nxt    = e1;
        case (state)
            OCC_EMPTY: begin
                if (push) begin
                    e0_nxt    = data_in;
                    state_nxt = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && take) begin
                    e0_nxt = data_in;
                end else if (push) begin
                    e1_nxt    = data_in;
                    state_nxt = OCC_TWO;
                end else if (take) begin
                    state_nxt = OCC_EMPTY;
                end
            end
            default: begin
                if (take) begin
                    e0_nxt = e1;
                    if (push) e1_nxt = data_in;
                    else state_nxt = OCC_ONE;
                end
            end
        endcase
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: fifo reader driving dpram port B into a FWFT stream; FIFO_RD_LEVEL_EN adds rd_level
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR = ADDR_W,
    parameter int DATA = DATA_W
) (
    input  logic            clK,
    input  logic            rst_N,
    input  logic [ADDR:0]   wr_ptr,
    output logic [ADDR:0]   rd_ptr,
    output logic            b_port_WR,
    output logic [ADDR-1:0] b_port_ADDR,
    output logic [DATA-1:0] b_port_data_IN,
    input  logic [DATA-1:0] b_port_data_OUT,
    output logic [DATA-1:0] dout_data,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic            empty
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR:0]   rd_level
`endif
);

    logic [ADDR:0] rd_q;
    logic          inflight;
    logic [1:0]    occ;
    logic          pop;
    logic          pending;
    logic          issue;

    assign pop     = dout_valid & dout_ready;
    assign pending = wr_ptr != rd_q;
    // room check written as occ+inflight < 2+pop so nothing can underflow
    assign issue   = pending & (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

    assign rd_ptr         = rd_q;
    assign b_port_WR      = 1'b0;
    assign b_port_ADDR    = rd_q[ADDR-1:0];
    assign b_port_data_IN = '0;
    assign empty          = ~dout_valid & ~inflight & ~pending;

`ifdef FIFO_RD_LEVEL_EN
    assign rd_level = (wr_ptr - rd_q) + (ADDR+1)'(occ) + (ADDR+1)'(inflight);
`endif

    // slot is freed at issue; the writer only sees it after the read word is registered
    always_ff @(posedge clK) begin
        if (!rst_N) begin
            rd_q     <= '0;
            inflight <= 1'b0;
        end else begin
            if (issue) rd_q <= rd_q + (ADDR+1)'(1);
            inflight <= issue;
        end
    end

    fifo_rd_skid #(.DATA(DATA)) u_skid (
        .clk      (clK),
        .rst_n    (rst_N),
        .push     (inflight),
        .data_in  (b_port_data_OUT),
        .pop      (dout_ready),
        .data_out (dout_data),
        .valid    (dout_valid),
        .occ      (occ)
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench for fifo_rd_ctrl with a behavioural RAM and writer
module tb_fifo_rd_ctrl;

    logic       clk;
    logic       rst_n;
    logic [4:0] wr_ptr;
    logic [4:0] rd_ptr;
    logic       b_wr;
    logic [3:0] b_addr;
    logic [7:0] b_din;
    logic [7:0] b_dout;
    logic [7:0] dout_data;
    logic       dout_valid;
    logic       dout_ready;
    logic       empty;
`ifdef FIFO_RD_LEVEL_EN
    logic [4:0] rd_level;
`endif
    logic [7:0] ram [16];
    int checks;
    int errors;

    fifo_rd_ctrl #(.ADDR(4), .DATA(8)) dut (
        .clK             (clk),
        .rst_N           (rst_n),
        .wr_ptr          (wr_ptr),
        .rd_ptr          (rd_ptr),
        .b_port_WR       (b_wr),
        .b_port_ADDR     (b_addr),
        .b_port_data_IN  (b_din),
        .b_port_data_OUT (b_dout),
        .dout_data       (dout_data),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .empty           (empty)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .rd_level        (rd_level)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) b_dout <= ram[b_addr];

    task automatic do_reset();
        rst_n = 1'b0;
        wr_ptr = '0;
        dout_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_ptr = 5'd5;
        dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (rd_ptr !== 5'd0) begin errors++; $display("FAIL reset_rd_ptr got %0h want 0", rd_ptr); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", dout_valid); end
        checks++; if (dout_data !== 8'h00) begin errors++; $display("FAIL reset_data got %0h want 0", dout_data); end
        checks++; if (b_wr !== 1'b0 || b_din !== 8'h00) begin errors++; $display("FAIL reset_bport wr %0b din %0h want 0 0", b_wr, b_din); end
        wr_ptr = 5'd0;
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", empty); end
        @(negedge clk);
        wr_ptr = 5'd5;
        rst_n = 1'b1;
        #1;
        checks++; if (b_addr !== 4'd0 || rd_ptr !== 5'd0) begin errors++; $display("FAIL release_addr got %0h/%0h want 0/0", b_addr, rd_ptr); end
        @(negedge clk);
        #1;
        checks++; if (rd_ptr !== 5'd1) begin errors++; $display("FAIL release_first_issue got %0h want 1", rd_ptr); end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        ram[0] = 8'hA5;
        wr_ptr = 5'd1;
        #1;
        checks++; if (b_addr !== 4'd0 || empty !== 1'b0) begin errors++; $display("FAIL single_T addr %0h empty %0b want 0 0", b_addr, empty); end
        @(negedge clk);
        #1;
        checks++; if (dout_valid !== 1'b0 || rd_ptr !== 5'd1) begin errors++; $display("FAIL single_T1 valid %0b rd_ptr %0h want 0 1", dout_valid, rd_ptr); end
        @(negedge clk);
        #1;
        checks++; if (dout_valid !== 1'b1 || dout_data !== 8'hA5) begin errors++; $display("FAIL single_T2 valid %0b data %0h want 1 a5", dout_valid, dout_data); end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        #1;
        checks++; if (empty !== 1'b1 || dout_valid !== 1'b0) begin errors++; $display("FAIL single_T3 empty %0b valid %0b want 1 0", empty, dout_valid); end
    endtask

    task automatic test_stream();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 16; i++) ram[i] = 8'(i);
        wr_ptr = 5'd16;
        dout_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL stream_latency valid %0b want 0", dout_valid); end
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            #1;
            checks++; if (dout_valid !== 1'b1 || dout_data !== 8'(k)) begin errors++; $display("FAIL stream_word%0d valid %0b data %0h want 1 %0h", k, dout_valid, dout_data, k); end
        end
        @(negedge clk);
        #1;
        checks++; if (rd_ptr !== 5'd16 || dout_valid !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL stream_end rd_ptr %0h valid %0b empty %0b want 10 0 1", rd_ptr, dout_valid, empty); end
        dout_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int got;
        got = 0;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) ram[i] = 8'(8'h40 + i);
        wr_ptr = 5'd4;
        repeat (5) @(negedge clk);
        #1;
        checks++; if (rd_ptr !== 5'd2) begin errors++; $display("FAIL bp_rd_ptr got %0h want 2", rd_ptr); end
        for (int c = 0; c < 3; c++) begin
            checks++; if (dout_valid !== 1'b1 || dout_data !== 8'h40) begin errors++; $display("FAIL bp_stall%0d valid %0b data %0h want 1 40", c, dout_valid, dout_data); end
            @(negedge clk);
            #1;
        end
        dout_ready = 1'b1;
        #1;
        for (int c = 0; c < 12 && got < 4; c++) begin
            if (dout_valid) begin
                checks++; if (dout_data !== 8'(8'h40 + got)) begin errors++; $display("FAIL bp_drain%0d got %0h want %0h", got, dout_data, 8'h40 + got); end
                got++;
            end
            @(negedge clk);
            #1;
        end
        checks++; if (got !== 4 || rd_ptr !== 5'd4) begin errors++; $display("FAIL bp_release popped %0d rd_ptr %0h want 4 4", got, rd_ptr); end
        dout_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int written;
        int popped;
        logic wrapped;
        logic [4:0] prev;
        written = 0;
        popped = 0;
        wrapped = 1'b0;
        do_reset();
        prev = 5'd0;
        for (int c = 0; c < 2000 && popped < 40; c++) begin
            @(negedge clk);
            if (written < 40 && 5'(wr_ptr - rd_ptr) < 5'd16 && $urandom_range(0, 3) != 0) begin
                ram[wr_ptr[3:0]] = 8'(written * 7 + 3);
                wr_ptr = wr_ptr + 5'd1;
                written++;
            end
            dout_ready = 1'($urandom_range(0, 1));
            #1;
`ifdef FIFO_RD_LEVEL_EN
            checks++; if (rd_level !== 5'(written - popped)) begin errors++; $display("FAIL wrap_level got %0d want %0d", rd_level, written - popped); end
`endif
            if (prev == 5'd31 && rd_ptr == 5'd0) wrapped = 1'b1;
            prev = rd_ptr;
            if (dout_valid && dout_ready) begin
                checks++; if (dout_data !== 8'(popped * 7 + 3)) begin errors++; $display("FAIL wrap_word%0d got %0h want %0h", popped, dout_data, 8'(popped * 7 + 3)); end
                popped++;
            end
        end
        checks++; if (popped !== 40) begin errors++; $display("FAIL wrap_count got %0d want 40", popped); end
        checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_seen got %0b want 1", wrapped); end
        checks++; if (rd_ptr !== 5'd8) begin errors++; $display("FAIL wrap_rd_ptr got %0h want 8", rd_ptr); end
        dout_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 8; i++) ram[i] = 8'(8'h80 + i);
        wr_ptr = 5'd8;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (dout_valid !== 1'b1 || dout_data !== 8'h81) begin errors++; $display("FAIL mid_pre valid %0b data %0h want 1 81", dout_valid, dout_data); end
        @(negedge clk);
        rst_n = 1'b0;
        wr_ptr = 5'd0;
        @(negedge clk);
        #1;
        checks++; if (dout_valid !== 1'b0 || rd_ptr !== 5'd0 || dout_data !== 8'h00) begin errors++; $display("FAIL mid_reset valid %0b rd_ptr %0h data %0h want 0 0 0", dout_valid, rd_ptr, dout_data); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_empty got %0b want 1", empty); end
`ifdef FIFO_RD_LEVEL_EN
        checks++; if (rd_level !== 5'd0) begin errors++; $display("FAIL mid_level got %0d want 0", rd_level); end
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dout_valid !== 1'b0 || rd_ptr !== 5'd0) begin errors++; $display("FAIL mid_after valid %0b rd_ptr %0h want 0 0", dout_valid, rd_ptr); end
        dout_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
        rst_n = 1'b0;
        wr_ptr = '0;
        dout_ready = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
